// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter:
//     - arb_state_t : FSM state encodings (S_IDLE=0, S_WAIT_ACT=1,
//                     S_WAIT_DONE=2, S_DRAIN=3)
//     - NUM_REQ_MAX : upper bound on the number of requesters
//     - wrap_inc()  : round-robin index increment with wrap-around
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

  localparam int NUM_REQ_MAX = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACT  = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_DRAIN     = 2'd3
  } arb_state_t;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Picks the first set bit of req at
//   or after ptr, wrapping NUM_REQ-1 -> 0.
//   Ports:
//     req  in   NUM_REQ  request vector
//     ptr  in   IDX_W    highest-priority index
//     pick out  NUM_REQ  one-hot winner (0 when no request)
//     idx  out  IDX_W    winner index (0 when no request)
//     any  out  1        at least one request present
// ---------------------------------------------------------------------------
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_num_req_check
      $error("rr_picker: NUM_REQ out of range");
    end
  endgenerate

  // Scan offsets from the far end back towards ptr so the closest
  // requester at or after ptr is the last (winning) assignment.
  always_comb begin
    int c;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (req[c]) begin
        idx = IDX_W'(c);
        any = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
      assign pick[gi] = any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx serialiser between NUM_REQ byte producers using
//   round-robin arbitration, one byte per frame.
//   Ports:
//     i_Clock      in   1          system clock (posedge)
//     i_Reset      in   1          synchronous active-high reset
//     i_Req_DV     in   NUM_REQ    per-requester byte valid, held until ack
//     i_Req_Byte   in   8*NUM_REQ  byte of requester n in [8n+7:8n]
//     i_Req_Last   in   NUM_REQ    last byte of packet (lock build only)
//     o_Req_Ack    out  NUM_REQ    one-cycle pulse: byte n taken
//     o_Grant      out  NUM_REQ    one-hot owner of byte in flight
//     o_Tx_DV      out  1          one-cycle start pulse to uart_tx
//     o_Tx_Byte    out  8          byte to uart_tx, stable until done
//     i_Tx_Active  in   1          uart_tx busy
//     i_Tx_Done    in   1          uart_tx end-of-frame (2 cycles)
//     o_Busy       out  1          arbiter not in S_IDLE
//   Build option: define UART_TX_ARB_LOCK_EN to keep the grant with one
//   requester until it sends a byte with i_Req_Last=1.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               tx_dv_reg, tx_dv_next;
  logic [7:0]         tx_byte_reg, tx_byte_next;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               issue;
  logic [7:0]         req_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_bytes
      assign req_bytes[gi] = i_Req_Byte[8*gi +: 8];
    end
  endgenerate

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_reg, lock_next;
  // While locked only the current owner may issue.
  assign eligible = lock_reg ? (i_Req_DV & grant_reg) : i_Req_DV;
`else
  logic unused_last;
  assign unused_last = ^i_Req_Last;
  assign eligible    = i_Req_DV;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req  (eligible),
    .ptr  (ptr_reg),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // uart_tx has no reset, so a frame may still be running after our reset;
  // never start while it is active or still signalling done.
  assign issue = (state_reg == S_IDLE) && pick_any && !i_Tx_Active && !i_Tx_Done;

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (issue)        state_next = S_WAIT_ACT;
      S_WAIT_ACT:  if (i_Tx_Active)  state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (i_Tx_Done)    state_next = S_DRAIN;
      S_DRAIN:     if (!i_Tx_Done)   state_next = S_IDLE;
      default:                       state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    tx_dv_next   = 1'b0;
    ack_next     = '0;
    tx_byte_next = tx_byte_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
`ifdef UART_TX_ARB_LOCK_EN
    lock_next    = lock_reg;
`endif
    if (issue) begin
      tx_dv_next   = 1'b1;
      ack_next     = pick;
      grant_next   = pick;
      tx_byte_next = req_bytes[pick_idx];
`ifdef UART_TX_ARB_LOCK_EN
      if (i_Req_Last[pick_idx]) begin
        lock_next = 1'b0;
        ptr_next  = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
      end else begin
        lock_next = 1'b1;
      end
`else
      ptr_next     = IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
`endif
    end else if (state_reg == S_DRAIN && !i_Tx_Done) begin
`ifdef UART_TX_ARB_LOCK_EN
      // A locked packet keeps its owner visible between bytes.
      if (!lock_reg) grant_next = '0;
`else
      grant_next = '0;
`endif
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      ptr_reg     <= '0;
      grant_reg   <= '0;
      ack_reg     <= '0;
      tx_dv_reg   <= 1'b0;
      tx_byte_reg <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_reg    <= 1'b0;
`endif
    end else begin
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      ack_reg     <= ack_next;
      tx_dv_reg   <= tx_dv_next;
      tx_byte_reg <= tx_byte_next;
`ifdef UART_TX_ARB_LOCK_EN
      lock_reg    <= lock_next;
`endif
    end
  end

  assign o_Req_Ack = ack_reg;
  assign o_Grant   = grant_reg;
  assign o_Tx_DV   = tx_dv_reg;
  assign o_Tx_Byte = tx_byte_reg;
  assign o_Busy    = (state_reg != S_IDLE);

endmodule
